// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, persistence filter,
// mode-selected edge pulse, sticky/overrun status and a combined interrupt.
module multi_edge_detector #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CH-1:0]   in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   out,
  output logic [CH-1:0]   sticky,
  output logic [CH-1:0]   overrun,
  output logic            irq
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   out_q;
    logic                   sticky_q;
    logic                   ovr_q;
    logic                   s;
    logic                   accept;
    logic                   pulse;

    // accept fires on the edge that completes FILT_CYCLES consecutive differing samples
    assign s      = sync_q[SYNC_STAGES-1];
    assign accept = (s != filt_q) && (cnt_q == CNT_W'(FILT_CYCLES - 1));
    assign pulse  = accept && (s ? mode[2*i] : mode[2*i+1]);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q   <= '0;
        filt_q   <= 1'b0;
        cnt_q    <= '0;
        out_q    <= 1'b0;
        sticky_q <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
        if (s == filt_q) begin
          cnt_q <= '0;
        end else if (accept) begin
          filt_q <= s;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        out_q    <= pulse;
        // a new event always wins over a simultaneous clear
        sticky_q <= pulse | (sticky_q & ~clr[i]);
        ovr_q    <= ~clr[i] & (ovr_q | (pulse & sticky_q));
      end
    end

    assign out[i]     = out_q;
    assign sticky[i]  = sticky_q;
    assign overrun[i] = ovr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |sticky;
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Randomised bench for multi_edge_detector against a cycle-level behavioural
// model built from input history and per-channel run lengths.
module tb_multi_edge_detector;

  localparam int CH          = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYCLES = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [CH-1:0]   din;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   out;
  logic [CH-1:0]   sticky;
  logic [CH-1:0]   overrun;
  logic            irq;

  int checks   = 0;
  int failures = 0;

  multi_edge_detector #(
    .CH(CH), .SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in(din), .mode(mode), .clr(clr),
    .out(out), .sticky(sticky), .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  // reference state
  logic [CH-1:0] hist[$];
  logic [CH-1:0] m_filt, m_out, m_sticky, m_ovr;
  logic          m_irq;
  int            run[CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < SYNC_STAGES; k++) hist.push_back('0);
    m_filt = '0; m_out = '0; m_sticky = '0; m_ovr = '0; m_irq = 1'b0;
    for (int k = 0; k < CH; k++) run[k] = 0;
  endtask

  // the filter sees the input captured SYNC_STAGES edges earlier
  task automatic model_edge();
    logic [CH-1:0] s;
    logic [CH-1:0] pulse;
    s = hist.pop_front();
    hist.push_back(din);
    pulse = '0;
    m_irq = |m_sticky;
    for (int k = 0; k < CH; k++) begin
      if (s[k] != m_filt[k]) begin
        run[k]++;
        if (run[k] >= FILT_CYCLES) begin
          m_filt[k] = s[k];
          run[k]    = 0;
          pulse[k]  = s[k] ? mode[2*k] : mode[2*k+1];
        end
      end else begin
        run[k] = 0;
      end
    end
    m_ovr    = ~clr & (m_ovr | (pulse & m_sticky));
    m_sticky = pulse | (m_sticky & ~clr);
    m_out    = pulse;
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, ".out"},     32'(out),     32'(m_out));
    chk({pfx, ".sticky"},  32'(sticky),  32'(m_sticky));
    chk({pfx, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({pfx, ".irq"},     32'(irq),     32'(m_irq));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all("cyc");
  endtask

  // asynchronous assertion mid-cycle, held for n edges, released after an edge
  task automatic do_reset(input int n);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all("rst_async");
    repeat (n) @(posedge clk);
    #1;
    compare_all("rst_hold");
    reset_n = 1'b1;
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    din     = '0;
    mode    = 8'h55;
    clr     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset_n = 1'b1;
    repeat (20) step();

    // latency of a clean rise on ch0
    din[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (out[0] === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(SYNC_STAGES + FILT_CYCLES));
    repeat (10) step();
    chk("sticky0_after_rise", 32'(sticky[0]), 32'd1);

    // two-cycle glitch on ch1 is rejected
    din[1] = 1'b1;
    repeat (2) step();
    din[1] = 1'b0;
    repeat (10) step();
    chk("glitch_sticky1", 32'(sticky[1]), 32'd0);

    // input held high across reset with ch0 enabled for rising edges
    din[0] = 1'b1;
    do_reset(3);
    repeat (10) step();
    chk("rst_rise_sticky0", 32'(sticky[0]), 32'd1);

    // random traffic with occasional mode changes, clears and resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < CH; k++)
        if ($urandom_range(5) == 0) din[k] = ~din[k];
      clr = '0;
      for (int k = 0; k < CH; k++)
        if ($urandom_range(7) == 0) clr[k] = 1'b1;
      if ($urandom_range(49) == 0) mode = 8'($urandom);
      if (cyc % 900 == 899) do_reset(1 + int'($urandom_range(3)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
